// File: rtl/lcd_text_driver.sv
// HD44780-style character LCD driver: a ROWS x COLS text buffer refreshed continuously to the panel.
// Define LCD_4BIT_EN to select the 4-bit bus (nibble) interface instead of the default 8-bit bus.
`timescale 1ns/1ps

module lcd_text_driver #(
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter int PWR_WAIT = 15000,
    parameter int E_PULSE  = 1,
    parameter int CMD_WAIT = 40,
    parameter int CLR_WAIT = 1640
) (
    input  logic       clk_1Mhz,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_row,
    input  logic [4:0] wr_col,
    input  logic [7:0] wr_char,
    output logic       wr_err,
    output logic       init_done,
    output logic       frame_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);
    localparam int DEPTH = 1 << AW;

    localparam logic [15:0] E_W      = 16'(E_PULSE);
    localparam logic [15:0] CMD_W    = 16'(CMD_WAIT);
    localparam logic [15:0] CLR_W    = 16'(CLR_WAIT);
    localparam logic [15:0] PWR_LAST = 16'(PWR_WAIT - 1);
    localparam logic [2:0]  ROWS_L   = 3'(ROWS);
    localparam logic [5:0]  COLS_L   = 6'(COLS);
    localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);
    localparam logic [4:0]  COL_LAST = 5'(COLS - 1);

`ifdef LCD_4BIT_EN
    localparam logic [2:0] INIT_LAST = 3'd4;
`else
    localparam logic [2:0] INIT_LAST = 3'd3;
`endif

    typedef enum logic [2:0] {PWR, INIT, ROWADDR, CHAR, NEXT} state_t;

    state_t      state, state_n;
    logic [15:0] tcnt, tcnt_n;
    logic [2:0]  init_idx, idx_n;
    logic [1:0]  row, row_n;
    logic [4:0]  col, col_n;
    logic [7:0]  xfer_byte, byte_c;
    logic [7:0]  src_c, rd_byte, data_c;
    logic [15:0] wait_c, last_c;
    logic        src_rs, done_c, e_c, rs_c, frame_c, init_c, wr_ok;
`ifdef LCD_4BIT_EN
    logic        single_c;
`endif

    logic [7:0]  mem [DEPTH];

    function automatic logic [AW-1:0] cell_idx(input logic [1:0] r, input logic [4:0] c);
        return AW'(int'(r) * COLS + int'(c));
    endfunction

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
`ifdef LCD_4BIT_EN
        // Entry 0 is the lone 0x2 nibble that switches the panel into 4-bit mode.
        case (idx)
            3'd0:    return 8'h20;
            3'd1:    return 8'h28;
            3'd2:    return 8'h0C;
            3'd3:    return 8'h06;
            default: return 8'h01;
        endcase
`else
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h06;
            default: return 8'h01;
        endcase
`endif
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    assign lcd_rw  = 1'b0;
    assign wr_ok   = wr_en && ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);
    assign rd_byte = mem[cell_idx(row, col)];

    // NOTE: the buffer is a register file, not a RAM macro, because reset must refill every cell with a space.
    always_ff @(posedge clk_1Mhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h20;
        end else if (wr_ok) begin
            mem[cell_idx(wr_row, wr_col)] <= wr_char;
        end
    end

    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt + 16'd1;
        idx_n   = init_idx;
        row_n   = row;
        col_n   = col;
        src_c   = 8'h00;
        src_rs  = 1'b0;
        frame_c = 1'b0;
        e_c     = 1'b0;
        rs_c    = lcd_rs;
        data_c  = lcd_data;

        case (state)
            INIT:    src_c = init_rom(init_idx);
            ROWADDR: src_c = 8'h80 | row_base(row);
            CHAR: begin
                src_c  = rd_byte;
                src_rs = 1'b1;
            end
            default: ;
        endcase

        // The byte is captured on transfer cycle 0, so later buffer writes cannot disturb the bus.
        byte_c = (tcnt == 16'd0) ? src_c : xfer_byte;
        wait_c = (!src_rs && byte_c == 8'h01) ? CLR_W : CMD_W;
`ifdef LCD_4BIT_EN
        single_c = (state == INIT) && (init_idx == 3'd0);
        last_c   = single_c ? (E_W + wait_c) : (E_W + E_W + 16'd1 + wait_c);
`else
        last_c   = E_W + wait_c;
`endif
        done_c = (tcnt == last_c);

        case (state)
            PWR: begin
                rs_c   = 1'b0;
                data_c = 8'h00;
                if (tcnt == PWR_LAST) begin
                    state_n = INIT;
                    tcnt_n  = 16'd0;
                end
            end
            INIT, ROWADDR, CHAR: begin
                rs_c = src_rs;
`ifdef LCD_4BIT_EN
                data_c = (single_c || tcnt <= E_W) ? {byte_c[7:4], 4'h0} : {byte_c[3:0], 4'h0};
                e_c    = (tcnt >= 16'd1 && tcnt <= E_W) ||
                         (!single_c && tcnt >= E_W + 16'd2 && tcnt <= E_W + E_W + 16'd1);
`else
                data_c = byte_c;
                e_c    = (tcnt != 16'd0) && (tcnt <= E_W);
`endif
                if (done_c) begin
                    tcnt_n = 16'd0;
                    case (state)
                        INIT: begin
                            if (init_idx == INIT_LAST) begin
                                state_n = ROWADDR;
                                row_n   = 2'd0;
                            end else begin
                                idx_n = init_idx + 3'd1;
                            end
                        end
                        ROWADDR: begin
                            state_n = CHAR;
                            col_n   = 5'd0;
                        end
                        default: begin
                            if (col == COL_LAST) state_n = NEXT;
                            else                 col_n   = col + 5'd1;
                        end
                    endcase
                end
            end
            NEXT: begin
                tcnt_n  = 16'd0;
                state_n = ROWADDR;
                if (row == ROW_LAST) begin
                    frame_c = 1'b1;
                    row_n   = 2'd0;
                end else begin
                    row_n = row + 2'd1;
                end
            end
            default: begin
                state_n = PWR;
                tcnt_n  = 16'd0;
            end
        endcase

        init_c = (state == ROWADDR) || (state == CHAR) || (state == NEXT);
    end

    always_ff @(posedge clk_1Mhz or posedge rst) begin
        if (rst) begin
            state     <= PWR;
            tcnt      <= 16'd0;
            init_idx  <= 3'd0;
            row       <= 2'd0;
            col       <= 5'd0;
            xfer_byte <= 8'h00;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            init_idx  <= idx_n;
            row       <= row_n;
            col       <= col_n;
            xfer_byte <= byte_c;
        end
    end

    // Pins are registered so the panel sees glitch-free strobes; reset clears them immediately.
    always_ff @(posedge clk_1Mhz or posedge rst) begin
        if (rst) begin
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            lcd_e      <= e_c;
            lcd_rs     <= rs_c;
            lcd_data   <= data_c;
            init_done  <= init_c;
            frame_done <= frame_c;
            wr_err     <= wr_en && !wr_ok;
        end
    end

endmodule
